// File: rtl/dm_bus_pkg.sv
// Shared types and constants for the data-memory bus bridge.
//   dm_state_e   : bridge FSM states (idle, request offered, waiting for response)
//   dm_bus_req_t : latched request payload; fields sized to the widest supported
//                  bus so any ADDR_W/DATA_W up to 64 fits without a new type
//   DM_TIMEOUT_DEFAULT : default response timeout in WAIT cycles
package dm_bus_pkg;

    localparam int unsigned DM_ADDR_W_MAX      = 64;
    localparam int unsigned DM_DATA_W_MAX      = 64;
    localparam int unsigned DM_MASK_W_MAX      = DM_DATA_W_MAX / 8;
    localparam int unsigned DM_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_REQ  = 2'd1,
        DM_WAIT = 2'd2
    } dm_state_e;

    typedef struct packed {
        logic [DM_ADDR_W_MAX-1:0] addr;
        logic [DM_DATA_W_MAX-1:0] wdata;
        logic [DM_MASK_W_MAX-1:0] wmask;
        logic                     we;
    } dm_bus_req_t;

endpackage

// File: rtl/dm_bus_bridge_if.sv
// Valid/ready request plus response channel between the bridge and the
// external data memory / system bus.
//   master : bridge side  - drives memReq{Valid,Addr,We,Wdata,Wmask}
//   slave  : memory side  - drives memReqReady, memRsp{Valid,Rdata,Err}
interface dm_bus_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic                  memReqValid;
    logic                  memReqReady;
    logic [ADDR_W-1:0]     memReqAddr;
    logic                  memReqWe;
    logic [DATA_W-1:0]     memReqWdata;
    logic [DATA_W/8-1:0]   memReqWmask;
    logic                  memRspValid;
    logic [DATA_W-1:0]     memRspRdata;
    logic                  memRspErr;

    modport master (
        output memReqValid, memReqAddr, memReqWe, memReqWdata, memReqWmask,
        input  memReqReady, memRspValid, memRspRdata, memRspErr
    );

    modport slave (
        input  memReqValid, memReqAddr, memReqWe, memReqWdata, memReqWmask,
        output memReqReady, memRspValid, memRspRdata, memRspErr
    );

endinterface

// File: rtl/dm_bus_bridge.sv
// Bridge from the single-cycle MEM-stage data bus to a valid/ready memory bus.
// Latches the request, offers it until accepted, waits for the response (or a
// timeout), stalls the pipeline meanwhile and registers load data for WB.
//   clk, rst           : clock, synchronous active-high reset
//   dataBus*           : MEM-stage request in, registered load data out
//   dmStall            : freeze IF..MEM while an access is pending
//   dmBusError         : one-cycle pulse in WB of a faulting / timed-out access
//   mem (master)       : memory request/response channel
module dm_bus_bridge
    import dm_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DM_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   dataBusAddr,
    input  logic [DATA_W-1:0]   dataBusWriteData,
    input  logic [DATA_W/8-1:0] dataBusWriteMask,
    input  logic                dataBusWriteEn,
    input  logic                dataBusReadEn,
    output logic [DATA_W-1:0]   dataBusReadData,
    output logic                dmStall,
    output logic                dmBusError,
    dm_bus_bridge_if.master     mem
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    dm_state_e   r_state;
    dm_state_e   w_state_next;
    dm_bus_req_t r_req;
    logic [DATA_W-1:0] r_rdata;
    logic        r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic w_req;
    logic w_cnt_last;
    logic w_accept;
    logic w_complete;
    logic w_timeout;
    logic w_stall;
    logic w_req_valid;

    assign w_req      = dataBusReadEn | dataBusWriteEn;
    // Counter starts at 0 in the first WAIT cycle, so the Nth WAIT cycle is the last.
    assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DM_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_req_valid  = 1'b0;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            DM_IDLE: begin
                if (w_req) begin
                    w_stall      = 1'b1;
                    w_state_next = DM_REQ;
                end
            end
            DM_REQ: begin
                w_req_valid = 1'b1;
                w_stall     = 1'b1;
                if (mem.memReqReady) begin
                    w_accept     = 1'b1;
                    w_state_next = DM_WAIT;
                end
            end
            DM_WAIT: begin
                // A response in the timeout cycle takes priority over the timeout.
                if (mem.memRspValid) begin
                    w_complete = 1'b1;
                end else if (w_cnt_last) begin
                    w_complete = 1'b1;
                    w_timeout  = 1'b1;
                end
                w_stall = ~w_complete;
                if (w_complete) begin
                    w_state_next = DM_IDLE;
                end
            end
            default: begin
                w_state_next = DM_IDLE;
            end
        endcase
        if (rst) begin
            w_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_err <= 1'b0;
            if (r_state == DM_IDLE && w_req) begin
                r_req.addr  <= DM_ADDR_W_MAX'(dataBusAddr);
                r_req.wdata <= DM_DATA_W_MAX'(dataBusWriteData);
                r_req.wmask <= dataBusWriteEn ? DM_MASK_W_MAX'(dataBusWriteMask) : '0;
                r_req.we    <= dataBusWriteEn;
            end
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == DM_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_complete) begin
                if (!r_req.we) begin
                    r_rdata <= w_timeout ? '0 : mem.memRspRdata;
                end
                r_err <= w_timeout | mem.memRspErr;
            end
        end
    end

    assign dmStall         = w_stall;
    assign dmBusError      = r_err;
    assign dataBusReadData = r_rdata;

    assign mem.memReqValid = w_req_valid;
    assign mem.memReqAddr  = ADDR_W'(r_req.addr);
    assign mem.memReqWe    = r_req.we;
    assign mem.memReqWdata = DATA_W'(r_req.wdata);
    assign mem.memReqWmask = MASK_W'(r_req.wmask);

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Directed self-checking bench for dm_bus_bridge (TIMEOUT_CYCLES = 4).
// Inputs change at the falling edge; outputs are checked 1ns later.
module tb_dm_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        stall;
    logic        berr;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;

    dm_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    dm_bus_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .dataBusAddr      (bus_addr),
        .dataBusWriteData (bus_wdata),
        .dataBusWriteMask (bus_wmask),
        .dataBusWriteEn   (bus_we),
        .dataBusReadEn    (bus_re),
        .dataBusReadData  (bus_rdata),
        .dmStall          (stall),
        .dmBusError       (berr),
        .mem              (mif.master)
    );

    always #5 clk = ~clk;

    // Counts accepted request handshakes, used to detect reissued requests.
    always @(posedge clk) begin
        if (!rst && mif.memReqValid && mif.memReqReady) n_acc <= n_acc + 1;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(); rst = 1'b1; bus_re = 1'b1; bus_addr = 32'h1234;
        cyc(); #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", stall); end
        n_chk++; if (mif.memReqValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", mif.memReqValid); end
        n_chk++; if (mif.memReqAddr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", mif.memReqAddr); end
        n_chk++; if (mif.memReqWe !== 1'b0 || mif.memReqWmask !== 4'h0 || mif.memReqWdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_payload got we=%b m=%h d=%h want 0", mif.memReqWe, mif.memReqWmask, mif.memReqWdata); end
        n_chk++; if (bus_rdata !== 32'h0 || berr !== 1'b0) begin
            n_fail++; $display("FAIL rst_rdata_err got %h/%b want 0/0", bus_rdata, berr); end
        bus_re = 1'b0;
        cyc(); rst = 1'b0;
    endtask

    task automatic test_load();
        cyc(); bus_re = 1'b1; bus_addr = 32'h100; #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall_c0 got %b want 1", stall); end
        cyc(); mif.memReqReady = 1'b1; #1;
        n_chk++; if (mif.memReqValid !== 1'b1 || mif.memReqAddr !== 32'h100) begin
            n_fail++; $display("FAIL ld_req got v=%b a=%h want 1/100", mif.memReqValid, mif.memReqAddr); end
        n_chk++; if (mif.memReqWe !== 1'b0 || mif.memReqWmask !== 4'h0) begin
            n_fail++; $display("FAIL ld_we_mask got %b/%h want 0/0", mif.memReqWe, mif.memReqWmask); end
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall_c1 got %b want 1", stall); end
        cyc(); mif.memReqReady = 1'b0; mif.memRspValid = 1'b1; mif.memRspRdata = 32'hDEADBEEF; #1;
        n_chk++; if (stall !== 1'b0 || mif.memReqValid !== 1'b0) begin
            n_fail++; $display("FAIL ld_c2 got stall=%b v=%b want 0/0", stall, mif.memReqValid); end
        cyc(); bus_re = 1'b0; mif.memRspValid = 1'b0; #1;
        n_chk++; if (bus_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_rdata got %h want deadbeef", bus_rdata); end
        n_chk++; if (berr !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL ld_c3 got err=%b stall=%b want 0/0", berr, stall); end
    endtask

    task automatic test_store_ready_delay();
        cyc(); bus_we = 1'b1; bus_addr = 32'h204; bus_wdata = 32'h0000AB00; bus_wmask = 4'b0010; #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL st_stall_c0 got %b want 1", stall); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 1) begin bus_addr = 32'hFFFFFFFC; bus_wdata = 32'hFFFFFFFF; bus_wmask = 4'hF; end
            #1;
            n_chk++; if (mif.memReqValid !== 1'b1 || mif.memReqAddr !== 32'h204 || mif.memReqWdata !== 32'h0000AB00
                         || mif.memReqWmask !== 4'b0010 || mif.memReqWe !== 1'b1 || stall !== 1'b1) begin
                n_fail++; $display("FAIL st_hold%0d got v=%b a=%h d=%h m=%h we=%b s=%b want 1/204/ab00/2/1/1", i,
                    mif.memReqValid, mif.memReqAddr, mif.memReqWdata, mif.memReqWmask, mif.memReqWe, stall); end
        end
        cyc(); mif.memReqReady = 1'b1; #1;
        n_chk++; if (mif.memReqValid !== 1'b1 || mif.memReqAddr !== 32'h204) begin
            n_fail++; $display("FAIL st_accept got v=%b a=%h want 1/204", mif.memReqValid, mif.memReqAddr); end
        cyc(); mif.memReqReady = 1'b0; mif.memRspValid = 1'b1; mif.memRspRdata = 32'h77777777; #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL st_ack_stall got %b want 0", stall); end
        cyc(); bus_we = 1'b0; mif.memRspValid = 1'b0; #1;
        n_chk++; if (bus_rdata !== 32'hDEADBEEF || berr !== 1'b0) begin
            n_fail++; $display("FAIL st_rdata_kept got %h/%b want deadbeef/0", bus_rdata, berr); end
    endtask

    task automatic test_error_rsp();
        cyc(); bus_re = 1'b1; bus_addr = 32'h300;
        cyc(); mif.memReqReady = 1'b1;
        cyc(); mif.memReqReady = 1'b0; mif.memRspValid = 1'b1; mif.memRspErr = 1'b1;
        mif.memRspRdata = 32'h12345678; #1;
        n_chk++; if (berr !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL err_c2 got err=%b stall=%b want 0/0", berr, stall); end
        cyc(); bus_re = 1'b0; mif.memRspValid = 1'b0; mif.memRspErr = 1'b0; #1;
        n_chk++; if (berr !== 1'b1 || bus_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL err_pulse got err=%b d=%h want 1/12345678", berr, bus_rdata); end
        cyc(); #1;
        n_chk++; if (berr !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle got %b want 0", berr); end
    endtask

    task automatic test_timeout();
        cyc(); bus_re = 1'b1; bus_addr = 32'h380;
        cyc(); mif.memReqReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); mif.memReqReady = 1'b0; #1;
            n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL to_wait%0d stall got %b want 1", i, stall); end
        end
        cyc(); #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL to_complete stall got %b want 0", stall); end
        cyc(); bus_re = 1'b0; #1;
        n_chk++; if (bus_rdata !== 32'h0 || berr !== 1'b1) begin
            n_fail++; $display("FAIL to_result got d=%h err=%b want 0/1", bus_rdata, berr); end
        cyc(); #1;
        n_chk++; if (berr !== 1'b0 || mif.memReqValid !== 1'b0) begin
            n_fail++; $display("FAIL to_idle got err=%b v=%b want 0/0", berr, mif.memReqValid); end
        cyc(); bus_re = 1'b1; bus_addr = 32'h400; #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL to_next_stall got %b want 1", stall); end
        cyc(); mif.memReqReady = 1'b1; #1;
        n_chk++; if (mif.memReqValid !== 1'b1 || mif.memReqAddr !== 32'h400) begin
            n_fail++; $display("FAIL to_next_req got v=%b a=%h want 1/400", mif.memReqValid, mif.memReqAddr); end
        cyc(); mif.memReqReady = 1'b0; mif.memRspValid = 1'b1; mif.memRspRdata = 32'hCAFEF00D;
        cyc(); bus_re = 1'b0; mif.memRspValid = 1'b0; #1;
        n_chk++; if (bus_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL to_next_rdata got %h want cafef00d", bus_rdata); end
    endtask

    task automatic test_reset_in_wait();
        cyc(); bus_re = 1'b1; bus_addr = 32'h700;
        cyc(); mif.memReqReady = 1'b1;
        cyc(); mif.memReqReady = 1'b0; rst = 1'b1; #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rw_stall_in_rst got %b want 0", stall); end
        cyc(); rst = 1'b0; bus_re = 1'b0; mif.memRspValid = 1'b1; mif.memRspRdata = 32'h55555555; #1;
        n_chk++; if (stall !== 1'b0 || mif.memReqValid !== 1'b0) begin
            n_fail++; $display("FAIL rw_idle got stall=%b v=%b want 0/0", stall, mif.memReqValid); end
        cyc(); mif.memRspValid = 1'b0; #1;
        n_chk++; if (bus_rdata !== 32'h0 || berr !== 1'b0) begin
            n_fail++; $display("FAIL rw_late_rsp got d=%h err=%b want 0/0", bus_rdata, berr); end
    endtask

    task automatic test_both_enables();
        cyc(); bus_re = 1'b1; bus_we = 1'b1; bus_addr = 32'h500; bus_wdata = 32'h11223344; bus_wmask = 4'hF;
        cyc(); mif.memReqReady = 1'b1; #1;
        n_chk++; if (mif.memReqWe !== 1'b1 || mif.memReqWmask !== 4'hF || mif.memReqWdata !== 32'h11223344) begin
            n_fail++; $display("FAIL both_we got we=%b m=%h d=%h want 1/f/11223344", mif.memReqWe, mif.memReqWmask,
                mif.memReqWdata); end
        cyc(); mif.memReqReady = 1'b0; mif.memRspValid = 1'b1; mif.memRspRdata = 32'h99999999;
        cyc(); bus_re = 1'b0; bus_we = 1'b0; mif.memRspValid = 1'b0; #1;
        n_chk++; if (bus_rdata !== 32'h0) begin n_fail++; $display("FAIL both_rdata_kept got %h want 0", bus_rdata); end
    endtask

    task automatic test_back_to_back();
        int acc0;
        acc0 = n_acc;
        cyc(); bus_re = 1'b1; bus_addr = 32'h600;
        cyc(); mif.memReqReady = 1'b1;
        cyc(); mif.memReqReady = 1'b0; mif.memRspValid = 1'b1; mif.memRspRdata = 32'hAAAA0001; #1;
        n_chk++; if (stall !== 1'b0 || mif.memReqValid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_c2 got stall=%b v=%b want 0/0", stall, mif.memReqValid); end
        cyc(); bus_addr = 32'h604; mif.memRspValid = 1'b0; #1;
        n_chk++; if (stall !== 1'b1 || mif.memReqValid !== 1'b0 || bus_rdata !== 32'hAAAA0001) begin
            n_fail++; $display("FAIL b2b_c3 got stall=%b v=%b d=%h want 1/0/aaaa0001", stall, mif.memReqValid,
                bus_rdata); end
        cyc(); mif.memReqReady = 1'b1; #1;
        n_chk++; if (mif.memReqValid !== 1'b1 || mif.memReqAddr !== 32'h604) begin
            n_fail++; $display("FAIL b2b_req2 got v=%b a=%h want 1/604", mif.memReqValid, mif.memReqAddr); end
        cyc(); mif.memReqReady = 1'b0; mif.memRspValid = 1'b1; mif.memRspRdata = 32'hBBBB0002; #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_c5 stall got %b want 0", stall); end
        cyc(); bus_re = 1'b0; mif.memRspValid = 1'b0; #1;
        n_chk++; if (bus_rdata !== 32'hBBBB0002 || mif.memReqValid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_c6 got d=%h v=%b want bbbb0002/0", bus_rdata, mif.memReqValid); end
        cyc(); cyc(); #1;
        n_chk++; if (n_acc - acc0 !== 2) begin n_fail++; $display("FAIL b2b_issue_count got %0d want 2", n_acc - acc0); end
    endtask

    initial begin
        rst = 1'b1; bus_addr = '0; bus_wdata = '0; bus_wmask = '0; bus_we = 1'b0; bus_re = 1'b0;
        mif.memReqReady = 1'b0; mif.memRspValid = 1'b0; mif.memRspRdata = '0; mif.memRspErr = 1'b0;
        test_reset();
        test_load();
        test_store_ready_delay();
        test_error_rsp();
        test_timeout();
        test_reset_in_wait();
        test_both_enables();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_bus_bridge.md
Name: dm_bus_bridge

Overview:
Sits directly downstream of dm_interface, between its combinational data-bus signals and the external data memory / system bus.
Converts the single-cycle dataBus request from the MEM stage into a valid/ready request plus response handshake, and stalls the pipeline until the access completes.
Registers load data so it is stable in the WB stage.
Flags bus errors and response timeouts.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (mask width = DATA_W/8)
TIMEOUT_CYCLES, 255, max cycles in WAIT before forced error completion (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
dataBusAddr  in  ADDR_W  request address from dm_interface
dataBusWriteData  in  DATA_W  lane-aligned store data
dataBusWriteMask  in  DATA_W/8  byte write enables
dataBusWriteEn  in  1  store request
dataBusReadEn  in  1  load request
dataBusReadData  out  DATA_W  registered load data, valid in WB stage
dmStall  out  1  freeze IF..MEM while an access is pending
dmBusError  out  1  one-cycle pulse: access ended with error or timeout
memReqValid  out  1  request valid
memReqReady  in  1  memory accepts request
memReqAddr  out  ADDR_W  request address
memReqWe  out  1  1 = write
memReqWdata  out  DATA_W  write data
memReqWmask  out  DATA_W/8  byte mask (0 for reads)
memRspValid  in  1  response/ack valid
memRspRdata  in  DATA_W  read data
memRspErr  in  1  response error

Behaviour:
- Reset (rst=1 at edge): state=IDLE; memReqValid=0; memReqAddr/Wdata/Wmask=0; memReqWe=0; dataBusReadData=0; dmBusError=0; timeout counter=0. dmStall forced 0 while rst=1.
- Reset mid-operation abandons the access. A response arriving afterwards in IDLE is ignored.
- FSM IDLE -> REQ -> WAIT -> IDLE.
- IDLE: a request (ReadEn|WriteEn) latches addr, wdata, mask and we=WriteEn into request registers, then goes to REQ.
  - If ReadEn and WriteEn are both set, the write wins.
  - For reads, the latched mask is 0.
- REQ: memReqValid=1. Payload is held stable until memReqReady=1, then goes to WAIT and clears the counter. memRspValid during REQ is ignored (protocol: no same-cycle response).
- WAIT: memReqValid=0; counter increments each cycle.
  - memRspValid=1: completes. If !memReqWe, dataBusReadData <= memRspRdata. dmBusError <= memRspErr. Goes to IDLE.
  - Counter reaches TIMEOUT_CYCLES without a response: completes. dataBusReadData <= 0 for reads. dmBusError <= 1. Goes to IDLE.
  - memRspValid on the same cycle as the timeout: the response wins.
- dmStall (combinational) = (state==IDLE && (ReadEn|WriteEn)) || state==REQ || (state==WAIT && !completing).
  - Stall drops in the completion cycle, so the pipeline advances at that edge.
  - The completed load is in WB the next cycle, with dataBusReadData updated at that same edge.
  - The MEM-stage request still visible in the completion cycle is not reissued, because state is WAIT.
- Minimum cost, ready=1 and response one cycle after accept: stall high 2 cycles, low in the 3rd.
- dataBusReadData holds its value until the next read completes. Writes leave it unchanged.
- dmBusError is high for exactly one cycle, the cycle after completion (WB of the faulting access); otherwise 0.
- Responses in IDLE or REQ: ignored.

Decomposition:
- Shared package dm_bus_pkg:
  - state enum typedef {DM_IDLE, DM_REQ, DM_WAIT}
  - packed struct dm_bus_req_t {addr, wdata, wmask, we}
  - default TIMEOUT constant
- No sub-module. The timeout counter is inline: width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Load, ready=1, rsp after 1 cycle: ReadEn, addr=0x100, rdata=0xDEADBEEF -> memReqValid/addr=0x100/we=0/wmask=0 in cycle1; dmStall=1,1,0; dataBusReadData=0xDEADBEEF in cycle3; dmBusError=0.
- Store, ready delayed 3 cycles: WriteEn, addr=0x204, data=0x0000AB00, mask=0b0010 -> payload stable 3 cycles; after ack, dmStall=0; dataBusReadData unchanged.
- Error response: load rsp with memRspErr=1 -> dmBusError=1 for exactly one cycle after completion; memRspRdata captured.
- Timeout: TIMEOUT_CYCLES=4, no response -> completion after 4 WAIT cycles; dataBusReadData=0; dmBusError pulse; FSM returns to IDLE and accepts the next request.
- Reset in WAIT, then late memRspValid in IDLE -> state IDLE, dmStall=0, late response ignored, dataBusReadData=0.
- ReadEn=WriteEn=1 -> memReqWe=1; back-to-back loads -> each issued exactly once, no reissue in the completion cycle.
